// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings, datapath widths and the arbiter FSM state type,
// shared by alu_arbiter and its round-robin sub-module.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  localparam logic [SEL_W-1:0] OP_FORWARD = 3'b000;
  localparam logic [SEL_W-1:0] OP_ADD     = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND     = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR      = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Codes 100-111 are reserved; the MSB alone identifies them.
  function automatic logic is_reserved_op(input logic [SEL_W-1:0] op);
    return op[SEL_W-1];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant. The pointer favours the requester
// that was not granted on the last accepted cycle; reset favours requester 0.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_ptr;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !r_ptr)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two valid/ready requesters, holding
// operands for SETTLE_CYCLES edges. Optional: ALU_ARB_ILLEGAL_OP_EN rejects reserved ops with ERR.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              VALID0,
  input  logic              VALID1,
  output logic              READY0,
  output logic              READY1,
  input  logic [SEL_W-1:0]  OP0,
  input  logic [SEL_W-1:0]  OP1,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] B0,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B1,
  output logic [DATA_W-1:0] RES,
  output logic              RES_VALID0,
  output logic              RES_VALID1,
  output logic              ERR,
  output logic [DATA_W-1:0] ALU_DATA1,
  output logic [DATA_W-1:0] ALU_DATA2,
  output logic [SEL_W-1:0]  ALU_SELECT,
  input  logic [DATA_W-1:0] ALU_RESULT
);

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic [SEL_W-1:0]  r_select;
  logic [DATA_W-1:0] r_res;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_last;
  logic [SEL_W-1:0]  w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  rr_arbiter2 u_rr (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .req     ({VALID1, VALID0}),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  // Gating with RESETN keeps both READYs low while reset is held.
  assign READY0   = RESETN && (r_state == IDLE) && w_gnt[0];
  assign READY1   = RESETN && (r_state == IDLE) && w_gnt[1];
  assign w_accept = READY0 || READY1;
  assign w_last   = (r_cnt == CNT_W'(1));

  assign w_op = w_gnt[1] ? OP1 : OP0;
  assign w_a  = w_gnt[1] ? A1  : A0;
  assign w_b  = w_gnt[1] ? B1  : B0;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = WAIT;
      WAIT:    if (w_last)   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic r_err;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_data1  <= '0;
      r_data2  <= '0;
      r_select <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_owner  <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      r_err    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_owner <= w_gnt[1];
`ifdef ALU_ARB_ILLEGAL_OP_EN
      r_err <= is_reserved_op(w_op);
      if (is_reserved_op(w_op)) begin
        // Rejected op: a single WAIT cycle, ALU inputs left as they were.
        r_cnt <= CNT_W'(1);
      end else begin
        r_cnt    <= SETTLE_INIT;
        r_data1  <= w_a;
        r_data2  <= w_b;
        r_select <= w_op;
      end
`else
      r_cnt    <= SETTLE_INIT;
      r_data1  <= w_a;
      r_data2  <= w_b;
      r_select <= w_op;
`endif
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
        r_res <= r_err ? '0 : ALU_RESULT;
`else
        r_res <= ALU_RESULT;
`endif
      end
    end
  end

  assign RES        = r_res;
  assign RES_VALID0 = (r_state == RESP) && !r_owner;
  assign RES_VALID1 = (r_state == RESP) &&  r_owner;
  assign ALU_DATA1  = r_data1;
  assign ALU_DATA2  = r_data2;
  assign ALU_SELECT = r_select;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign ERR = (r_state == RESP) && r_err;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (settle 1 and 3) each driving a behavioural ALU, checked
// every cycle against a timeline model of accepts and responses, plus literal expectations.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int S0 = 1;
  localparam int S1 = 3;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  localparam logic       EXP_ERR = 1'b1;
  localparam int         EXP_LAT = 2;
  localparam logic [2:0] EXP_SEL = 3'b011;
`else
  localparam logic       EXP_ERR = 1'b0;
  localparam int         EXP_LAT = S1 + 1;
  localparam logic [2:0] EXP_SEL = 3'b101;
`endif

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  logic       v0 [2];
  logic       v1 [2];
  logic [2:0] op0 [2];
  logic [2:0] op1 [2];
  logic [7:0] a0 [2];
  logic [7:0] b0 [2];
  logic [7:0] a1 [2];
  logic [7:0] b1 [2];
  logic       rdy0 [2];
  logic       rdy1 [2];
  logic       rv0 [2];
  logic       rv1 [2];
  logic       err [2];
  logic [7:0] res [2];
  logic [7:0] d1 [2];
  logic [7:0] d2 [2];
  logic [2:0] sel [2];
  logic [7:0] alu_res [2];

  function automatic int settle(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      OP_FORWARD: return x;
      OP_ADD:     return x + y;
      OP_AND:     return x & y;
      OP_OR:      return x | y;
      default:    return 8'h00;
    endcase
  endfunction

  assign alu_res[0] = alu_f(sel[0], d1[0], d2[0]);
  assign alu_res[1] = alu_f(sel[1], d1[1], d2[1]);

  alu_arbiter #(.SETTLE_CYCLES(S0)) u_dut0 (
    .CLK(clk), .RESETN(rst_n), .VALID0(v0[0]), .VALID1(v1[0]), .READY0(rdy0[0]), .READY1(rdy1[0]),
    .OP0(op0[0]), .OP1(op1[0]), .A0(a0[0]), .B0(b0[0]), .A1(a1[0]), .B1(b1[0]), .RES(res[0]),
    .RES_VALID0(rv0[0]), .RES_VALID1(rv1[0]), .ERR(err[0]), .ALU_DATA1(d1[0]), .ALU_DATA2(d2[0]),
    .ALU_SELECT(sel[0]), .ALU_RESULT(alu_res[0])
  );

  alu_arbiter #(.SETTLE_CYCLES(S1)) u_dut1 (
    .CLK(clk), .RESETN(rst_n), .VALID0(v0[1]), .VALID1(v1[1]), .READY0(rdy0[1]), .READY1(rdy1[1]),
    .OP0(op0[1]), .OP1(op1[1]), .A0(a0[1]), .B0(b0[1]), .A1(a1[1]), .B1(b1[1]), .RES(res[1]),
    .RES_VALID0(rv0[1]), .RES_VALID1(rv1[1]), .ERR(err[1]), .ALU_DATA1(d1[1]), .ALU_DATA2(d2[1]),
    .ALU_SELECT(sel[1]), .ALU_RESULT(alu_res[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: per instance, the cycle the arbiter is free again, the cycle of
  // the pending response and its contents, and the values the ALU outputs must hold.
  bit         m_ptr  [2];
  int         m_free [2];
  int         m_rcyc [2];
  bit         m_rown [2];
  bit         m_rerr [2];
  logic [7:0] m_rval [2];
  logic [7:0] m_res  [2];
  logic [7:0] m_d1   [2];
  logic [7:0] m_d2   [2];
  logic [2:0] m_sel  [2];
  bit e_r0, e_r1, e_v0, e_v1, e_er, win1;

  task automatic model_accept(input int i, input bit who);
    logic [2:0] op = who ? op1[i] : op0[i];
    logic [7:0] a  = who ? a1[i]  : a0[i];
    logic [7:0] b  = who ? b1[i]  : b0[i];
    m_ptr[i]  = !who;
    m_rown[i] = who;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    if (op[2]) begin
      m_rval[i] = 8'h00;
      m_rerr[i] = 1'b1;
      m_rcyc[i] = cyc + 2;
      m_free[i] = cyc + 3;
    end else
`endif
    begin
      m_d1[i]   = a;
      m_d2[i]   = b;
      m_sel[i]  = op;
      m_rval[i] = alu_f(op, a, b);
      m_rerr[i] = 1'b0;
      m_rcyc[i] = cyc + 1 + settle(i);
      m_free[i] = cyc + 2 + settle(i);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_ptr[i] = 0; m_free[i] = 0; m_rcyc[i] = -1; m_rown[i] = 0; m_rerr[i] = 0;
        m_rval[i] = 0; m_res[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_sel[i] = 0;
        e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0; e_er = 0;
      end else begin
        if (cyc == m_rcyc[i]) m_res[i] = m_rval[i];
        e_v0 = (cyc == m_rcyc[i]) && !m_rown[i];
        e_v1 = (cyc == m_rcyc[i]) &&  m_rown[i];
        e_er = (cyc == m_rcyc[i]) &&  m_rerr[i];
        if (v0[i] && v1[i]) win1 = m_ptr[i];
        else                win1 = v1[i];
        e_r0 = (cyc >= m_free[i]) && (v0[i] || v1[i]) && !win1;
        e_r1 = (cyc >= m_free[i]) && (v0[i] || v1[i]) &&  win1;
      end
      check($sformatf("u%0d.READY0", i), rdy0[i], e_r0);
      check($sformatf("u%0d.READY1", i), rdy1[i], e_r1);
      check($sformatf("u%0d.RES_VALID0", i), rv0[i], e_v0);
      check($sformatf("u%0d.RES_VALID1", i), rv1[i], e_v1);
      check($sformatf("u%0d.ERR", i), err[i], e_er);
      check($sformatf("u%0d.RES", i), res[i], m_res[i]);
      check($sformatf("u%0d.ALU_DATA1", i), d1[i], m_d1[i]);
      check($sformatf("u%0d.ALU_DATA2", i), d2[i], m_d2[i]);
      check($sformatf("u%0d.ALU_SELECT", i), sel[i], m_sel[i]);
      if (e_r0 || e_r1) model_accept(i, e_r1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run(input int i, input bit en0, input bit en1,
                     input logic [2:0] o0, input logic [7:0] x0, input logic [7:0] y0,
                     input logic [2:0] o1, input logic [7:0] x1, input logic [7:0] y1,
                     output int ac0, output int ac1, output int rc0, output int rc1,
                     output logic [7:0] r0, output logic [7:0] r1, output logic e0);
    bit done = 1'b0;
    ac0 = -1; ac1 = -1; rc0 = -1; rc1 = -1; r0 = '0; r1 = '0; e0 = 1'b0;
    op0[i] = o0; a0[i] = x0; b0[i] = y0; v0[i] = en0;
    op1[i] = o1; a1[i] = x1; b1[i] = y1; v1[i] = en1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (rdy0[i] && ac0 < 0) ac0 = cyc;
      if (rdy1[i] && ac1 < 0) ac1 = cyc;
      if (rv0[i] && rc0 < 0) begin rc0 = cyc; r0 = res[i]; e0 = err[i]; end
      if (rv1[i] && rc1 < 0) begin rc1 = cyc; r1 = res[i]; end
      done = (!en0 || rc0 >= 0) && (!en1 || rc1 >= 0);
      tick();
      if (ac0 >= 0) v0[i] = 1'b0;
      if (ac1 >= 0) v1[i] = 1'b0;
    end
    v0[i] = 1'b0;
    v1[i] = 1'b0;
    if (en0) check($sformatf("u%0d.resp0_seen", i), rc0 >= 0, 1);
    if (en1) check($sformatf("u%0d.resp1_seen", i), rc1 >= 0, 1);
  endtask

  int         ac0, ac1, rc0, rc1, n_pulse;
  logic [7:0] r0, r1;
  logic       e0;
  bit         got;
  int         acc_c [$];
  bit         acc_w [$];

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 0; v1[i] = 0; op0[i] = 0; op1[i] = 0; a0[i] = 0; b0[i] = 0; a1[i] = 0; b1[i] = 0;
    end
    #1 rst_n = 1'b0;
    tick();
    check("reset.RES", res[0], 8'h00);
    check("reset.ALU_SELECT", sel[1], 3'b000);
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester ADD, settle 1.
    run(0, 1, 0, OP_ADD, 8'd5, 8'd3, 3'd0, 8'd0, 8'd0, ac0, ac1, rc0, rc1, r0, r1, e0);
    check("t1.res", r0, 8'd8);
    check("t1.latency", rc0 - ac0, 2);

    // Simultaneous requests after reset: requester 0 first, then 1.
    do_reset();
    run(0, 1, 1, OP_AND, 8'hF0, 8'h3C, OP_OR, 8'h0F, 8'h30, ac0, ac1, rc0, rc1, r0, r1, e0);
    check("t2.res0", r0, 8'h30);
    check("t2.res1", r1, 8'h3F);
    check("t2.order", rc0 < rc1, 1);
    check("t2.accept_gap", ac1 - ac0, 3);

    // Continuous requests on the settle-3 instance.
    op0[1] = OP_ADD; a0[1] = 8'd10;  b0[1] = 8'd20;
    op1[1] = OP_AND; a1[1] = 8'hF0;  b1[1] = 8'h3C;
    v0[1] = 1'b1; v1[1] = 1'b1;
    repeat (32) begin
      @(negedge clk);
      if (rdy0[1]) begin acc_c.push_back(cyc); acc_w.push_back(1'b0); end
      if (rdy1[1]) begin acc_c.push_back(cyc); acc_w.push_back(1'b1); end
      tick();
    end
    v0[1] = 1'b0; v1[1] = 1'b0;
    repeat (8) tick();
    check("t4.accept_count", acc_c.size(), 7);
    if (acc_w.size() > 0) check("t4.first_grant", acc_w[0], 0);
    for (int j = 1; j < acc_c.size(); j++) begin
      check("t4.accept_gap", acc_c[j] - acc_c[j-1], 5);
      check("t4.alternate", acc_w[j] != acc_w[j-1], 1);
    end

    // Signed ADD and FORWARD.
    run(0, 1, 0, OP_ADD, 8'hFC, 8'h02, 3'd0, 8'd0, 8'd0, ac0, ac1, rc0, rc1, r0, r1, e0);
    check("t3.signed_add", r0, 8'hFE);
    run(0, 0, 1, 3'd0, 8'd0, 8'd0, OP_FORWARD, 8'h7E, 8'h7E, ac0, ac1, rc0, rc1, r0, r1, e0);
    check("t3.forward", r1, 8'h7E);

    // Reset pulsed while the settle-3 instance is in WAIT.
    op0[1] = OP_ADD; a0[1] = 8'd7; b0[1] = 8'd1; v0[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rdy0[1];
      tick();
    end
    v0[1] = 1'b0;
    check("t5.accepted", got, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("t5.reset_res", res[1], 8'h00);
    check("t5.reset_data1", d1[1], 8'h00);
    check("t5.reset_select", sel[1], 3'b000);
    tick();
    tick();
    rst_n = 1'b1;
    n_pulse = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv0[1] || rv1[1]) n_pulse++;
    end
    tick();
    check("t5.abandoned_resp", n_pulse, 0);
    run(1, 0, 1, 3'd0, 8'd0, 8'd0, OP_OR, 8'h55, 8'hAA, ac0, ac1, rc0, rc1, r0, r1, e0);
    check("t5.after_reset", r1, 8'hFF);

    // Reserved op on the settle-3 instance.
    run(1, 1, 0, 3'b101, 8'd1, 8'd1, 3'd0, 8'd0, 8'd0, ac0, ac1, rc0, rc1, r0, r1, e0);
    check("t6.res", r0, 8'h00);
    check("t6.err", e0, EXP_ERR);
    check("t6.latency", rc0 - ac0, EXP_LAT);
    check("t6.select", sel[1], EXP_SEL);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
